// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the program loader, the CPU and program memory:
//   program memory geometry and the loader FSM state encoding.
package prog_loader_pkg;

  localparam int PMEM_ADDR_W = 6;
  localparam int PMEM_DEPTH  = 64;
  localparam int INST_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // States in which start is honoured.
  function automatic logic is_restartable(state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_xsum.sv
// prog_loader_xsum
//   8-bit running XOR of the accepted stream bytes.
//   Ports:
//     clk     in  clock
//     i_clr   in  clear the accumulator (takes priority over i_en)
//     i_en    in  fold i_data into the accumulator
//     i_data  in  byte to fold in
//     o_sum   out current accumulator value
//   The accumulator is pure data: it is cleared by i_clr at the start of
//   every load, so it needs no reset of its own.
module prog_loader_xsum (
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_sum
);

  logic [7:0] r_sum;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_sum <= 8'h00;
    end else if (i_en) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Fills the CPU program memory from a length-prefixed byte stream.
//   Stream: N (word count, 0..DEPTH), then N {hi, lo} byte pairs, then a
//   checksum byte when PROG_LOADER_CHECKSUM_EN is defined (running XOR of
//   all preceding bytes of the load, N included).
//   Configuration macro: PROG_LOADER_CHECKSUM_EN (checksum byte/check).
//   Ports:
//     clk       in   clock, rising edge
//     reset     in   synchronous, active-high
//     start     in   begin a load (honoured in IDLE, DONE, ERR)
//     in_valid  in   byte source has in_data valid
//     in_data   in   stream byte
//     in_ready  out  loader accepts a byte this cycle
//     wr_en     out  program memory write strobe, one cycle per word
//     wr_addr   out  program memory write address
//     wr_data   out  instruction word {hi, lo}
//     cpu_hold  out  holds the CPU in reset while loading / on error
//     done      out  image loaded, CPU released
//     err       out  bad length or checksum, CPU stays held
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = PMEM_ADDR_W,
  parameter int DEPTH  = PMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              r_state;
  logic                r_in_ready;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [INST_W-1:0]   r_wr_data;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_cnt;
  logic [7:0]          r_hi;

  logic                w_accept;
  logic                w_start;

  // in_ready is registered, so a byte offered together with start is not
  // taken: in_ready is still 0 in the cycle start is seen.
  assign w_accept = in_valid && r_in_ready;
  assign w_start  = start && is_restartable(r_state);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] w_xsum;

  prog_loader_xsum u_xsum (
    .clk    (clk),
    .i_clr  (w_start),
    .i_en   (w_accept && (r_state != ST_CHK)),
    .i_data (in_data),
    .o_sum  (w_xsum)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_state    <= ST_LEN;
        r_in_ready <= 1'b1;
        r_cpu_hold <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        case (r_state)
          ST_LEN: begin
            if (w_accept) begin
              if (in_data > DEPTH_B) begin
                r_state    <= ST_ERR;
                r_in_ready <= 1'b0;
                r_err      <= 1'b1;
              end else if (in_data == 8'h00) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                r_state    <= ST_CHK;
`else
                r_state    <= ST_DONE;
                r_in_ready <= 1'b0;
`endif
              end else begin
                r_state <= ST_HI;
                r_cnt   <= in_data[ADDR_W:0];
                r_ptr   <= '0;
              end
            end
          end
          ST_HI: begin
            if (w_accept) begin
              r_hi    <= in_data;
              r_state <= ST_LO;
            end
          end
          ST_LO: begin
            if (w_accept) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr;
              r_wr_data <= {r_hi, in_data};
              // ptr may step past the top address after the final word of a
              // full image; it is never used again before being reloaded.
              r_ptr     <= r_ptr + 1'b1;
              r_cnt     <= r_cnt - 1'b1;
              if (r_cnt == CNT_ONE) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                r_state    <= ST_CHK;
`else
                r_state    <= ST_DONE;
                r_in_ready <= 1'b0;
`endif
              end else begin
                r_state <= ST_HI;
              end
            end
          end
          ST_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            if (w_accept) begin
              r_in_ready <= 1'b0;
              if (in_data == w_xsum) begin
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end
`else
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
`endif
          end
          ST_DONE: begin
            // Release one cycle after entering DONE, so the CPU leaves reset
            // only after the final word write has landed in memory.
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end
          ST_ERR: begin
            r_err <= 1'b1;
          end
          default: begin
            r_in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader: scenario tasks drive the byte stream,
//   expected memory writes go into a queue that a negedge monitor pops.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];
  logic [15:0] img[64];

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [21:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_wr got addr=%0d data=%h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_word got addr=%0d data=%h, expected addr=%0d data=%h",
                   wr_addr, wr_data, e[21:16], e[15:0]);
        end
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checks++;
      if (cpu_hold !== 1'b1) begin
        errors++;
        $display("FAIL hold_during_gap got cpu_hold=%b, expected 1", cpu_hold);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL ready_timeout got in_ready=%b, expected 1 within 20 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends N, img[0..n-1] and (if built in) the checksum; checks each write
  // is visible exactly one cycle after its LO byte.
  task automatic run_load(input int n, input int gap, input bit bad_chk);
    logic [7:0] x;
    x = n[7:0];
    send_byte(n[7:0], gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({i[5:0], img[i]});
      send_byte(img[i][15:8], gap);
      send_byte(img[i][7:0], gap);
      checks++;
      if (wr_en !== 1'b1) begin
        errors++;
        $display("FAIL wr_latency word %0d got wr_en=%b, expected 1", i, wr_en);
      end
      x = x ^ img[i][15:8] ^ img[i][7:0];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, gap);
`else
    if (bad_chk) x = 8'h00;
`endif
  endtask

  // Called on the falling edge right after the final byte was taken.
  task automatic check_finish(input bit exp_err, input string name);
    if (exp_err) begin
      checks++;
      if ({err, done, cpu_hold, in_ready} !== 4'b1010) begin
        errors++;
        $display("FAIL %s_err got err=%b done=%b hold=%b rdy=%b, expected 1 0 1 0",
                 name, err, done, cpu_hold, in_ready);
      end
    end else begin
      checks++;
      if ({done, cpu_hold, in_ready} !== 3'b010) begin
        errors++;
        $display("FAIL %s_pre_done got done=%b hold=%b rdy=%b, expected 0 1 0",
                 name, done, cpu_hold, in_ready);
      end
      @(negedge clk);
      checks++;
      if ({done, cpu_hold, err} !== 3'b100) begin
        errors++;
        $display("FAIL %s_done got done=%b hold=%b err=%b, expected 1 0 0",
                 name, done, cpu_hold, err);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_wr got %0d writes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_basic_image();
    img[0] = 16'h0004; img[1] = 16'h0105; img[2] = 16'h2021;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b wr=%b addr=%0d data=%h hold=%b done=%b err=%b, expected all 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, cpu_hold, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_outputs got rdy=%b hold=%b done=%b err=%b, expected 0", in_ready, cpu_hold, done, err);
    end
  endtask

  task automatic test_basic();
    set_basic_image();
    pulse_start();
    checks++;
    if ({in_ready, cpu_hold} !== 2'b11) begin
      errors++;
      $display("FAIL start_len got rdy=%b hold=%b, expected 1 1", in_ready, cpu_hold);
    end
    run_load(3, 0, 1'b0);
    check_finish(1'b0, "basic");
  endtask

  task automatic test_backpressure();
    set_basic_image();
    pulse_start();
    run_load(3, 3, 1'b0);
    check_finish(1'b0, "bp");
  endtask

  task automatic test_lengths();
    pulse_start();
    run_load(0, 0, 1'b0);
    check_finish(1'b0, "len0");
    for (int i = 0; i < 64; i++) img[i] = 16'($urandom);
    pulse_start();
    run_load(64, 0, 1'b0);
    check_finish(1'b0, "len64");
    pulse_start();
    send_byte(8'h41, 0);
    check_finish(1'b1, "len65");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    img[0] = 16'h1234;
    pulse_start();
    send_byte(8'h01, 0);
    exp_q.push_back({6'd0, 16'h1234});
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h27, 0);
    check_finish(1'b0, "chk_ok");
    pulse_start();
    run_load(1, 0, 1'b1);
    check_finish(1'b1, "chk_bad");
  endtask
`endif

  task automatic test_reset_midload();
    set_basic_image();
    pulse_start();
    send_byte(8'h03, 0);
    exp_q.push_back({6'd0, img[0]});
    send_byte(img[0][15:8], 0);
    send_byte(img[0][7:0], 0);
    send_byte(img[1][15:8], 0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !== 28'h0) begin
      errors++;
      $display("FAIL midload_reset got rdy=%b wr=%b addr=%0d data=%h hold=%b done=%b err=%b, expected all 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    run_load(3, 0, 1'b0);
    check_finish(1'b0, "reload");
  endtask

  task automatic test_restart();
    set_basic_image();
    pulse_start();
    send_byte(8'h02, 0);
    pulse_start();
    checks++;
    if ({in_ready, cpu_hold, done} !== 3'b110) begin
      errors++;
      $display("FAIL busy_start got rdy=%b hold=%b done=%b, expected 1 1 0", in_ready, cpu_hold, done);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({i[5:0], img[i]});
      send_byte(img[i][15:8], 0);
      send_byte(img[i][7:0], 0);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h02 ^ img[0][15:8] ^ img[0][7:0] ^ img[1][15:8] ^ img[1][7:0], 0);
`endif
    check_finish(1'b0, "busy_start");
    pulse_start();
    checks++;
    if ({done, err, cpu_hold, in_ready} !== 4'b0011) begin
      errors++;
      $display("FAIL restart_from_done got done=%b err=%b hold=%b rdy=%b, expected 0 0 1 1",
               done, err, cpu_hold, in_ready);
    end
    send_byte(8'h50, 0);
    check_finish(1'b1, "restart_err");
    pulse_start();
    checks++;
    if ({done, err, cpu_hold, in_ready} !== 4'b0011) begin
      errors++;
      $display("FAIL restart_from_err got done=%b err=%b hold=%b rdy=%b, expected 0 0 1 1",
               done, err, cpu_hold, in_ready);
    end
    run_load(1, 0, 1'b0);
    check_finish(1'b0, "after_err");
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_lengths();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
